// File: rtl/concat_stream.sv
// Channel-concatenation stage: forwards one frame of source A words, then one
// frame of source B words, through a single registered valid/ready output stage.
module concat_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int D_A        = 3,
  parameter int D_B        = 3,
  parameter int W          = 4,
  parameter int H          = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [DATA_WIDTH-1:0] b_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy
);

  localparam int NA   = D_A * W * H;
  localparam int NB   = D_B * W * H;
  localparam int MAXN = (NA > NB) ? NA : NB;
  localparam int CW   = $clog2(MAXN) + 1;

  localparam logic [CW-1:0] LAST_A = CW'(NA - 1);
  localparam logic [CW-1:0] LAST_B = CW'(NB - 1);

  typedef enum logic {S_A, S_B} state_t;

  state_t                  state, state_next;
  logic [CW-1:0]           counter, counter_next;
  logic [DATA_WIDTH-1:0]   data_next;
  logic                    valid_next, last_next, busy_next;
  logic                    free, a_fire, b_fire;

  // Readies depend only on registered state and out_ready, never on the valids.
  assign free    = !out_valid || out_ready;
  assign a_ready = (state == S_A) && free;
  assign b_ready = (state == S_B) && free;
  assign a_fire  = a_valid && a_ready;
  assign b_fire  = b_valid && b_ready;

  always_comb begin
    state_next   = state;
    counter_next = counter;
    data_next    = out_data;
    valid_next   = out_valid;
    last_next    = out_last;
    busy_next    = busy;

    if (free) begin
      valid_next = 1'b0;
      last_next  = 1'b0;
    end

    case (state)
      S_A: begin
        if (a_fire) begin
          valid_next = 1'b1;
          data_next  = a_data;
          if (counter == LAST_A) begin
            counter_next = '0;
            state_next   = S_B;
          end else begin
            counter_next = counter + CW'(1);
          end
        end
      end
      S_B: begin
        if (b_fire) begin
          valid_next = 1'b1;
          data_next  = b_data;
          if (counter == LAST_B) begin
            counter_next = '0;
            state_next   = S_A;
            last_next    = 1'b1;
          end else begin
            counter_next = counter + CW'(1);
          end
        end
      end
      default: state_next = S_A;
    endcase

    // A new frame starting on the same edge the previous one drains keeps busy high.
    if (out_valid && out_ready && out_last) busy_next = 1'b0;
    if (a_fire) busy_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_A;
      counter   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      counter   <= counter_next;
      out_data  <= data_next;
      out_valid <= valid_next;
      out_last  <= last_next;
      busy      <= busy_next;
    end
  end

endmodule

// File: tb/tb_concat_stream.sv
// Directed bench for concat_stream with D_A=2, D_B=1, W=2, H=2 (8 A words, 4 B words per frame).
module tb_concat_stream;

  localparam int NA = 8;
  localparam int NB = 4;
  localparam int FW = NA + NB;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] a_data, b_data, out_data;
  logic        a_valid, a_ready, b_valid, b_ready;
  logic        out_valid, out_ready, out_last, busy;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int a_sent, b_sent, first_a;

  logic [15:0] cap_data[$];
  logic        cap_last[$];
  logic        cap_busy[$];
  int          cap_cyc[$];

  concat_stream #(.DATA_WIDTH(16), .D_A(2), .D_B(1), .W(2), .H(2)) dut (
    .clk(clk), .reset(reset),
    .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] expWord(input int k);
    int pos;
    pos = k % FW;
    return (pos < NA) ? 16'(pos) : 16'h0100 + 16'(pos - NA);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Inputs change on the falling edge; handshakes are evaluated #1 later, ahead of the rising edge.
  task automatic applyStimulus(input int frames, input int ready_mode, input int stop_a, input int budget);
    int steps;
    steps = 0;
    a_sent = 0;
    b_sent = 0;
    first_a = -1;
    cap_data.delete();
    cap_last.delete();
    cap_busy.delete();
    cap_cyc.delete();
    while (1) begin
      if (stop_a == 0 && cap_data.size() >= frames * FW) break;
      if (stop_a > 0 && a_sent >= stop_a) break;
      if (steps >= budget) begin
        if (stop_a > 0) checkOutput("timeout_a_words", a_sent, stop_a);
        else checkOutput("timeout_out_words", cap_data.size(), frames * FW);
        break;
      end
      @(negedge clk);
      steps++;
      cyc++;
      a_valid   = (a_sent < frames * NA);
      a_data    = 16'(a_sent % NA);
      b_valid   = (b_sent < frames * NB);
      b_data    = 16'h0100 + 16'(b_sent % NB);
      out_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      #1;
      if (frames == 1 && ready_mode == 0 && stop_a == 0 && a_sent < NA)
        checkOutput("b_ready_during_A", b_ready, 0);
      if (out_valid && !out_ready) begin
        checkOutput("a_ready_stall", a_ready, 0);
        checkOutput("b_ready_stall", b_ready, 0);
        checkOutput("stall_data", out_data, expWord(cap_data.size()));
        checkOutput("stall_last", out_last, (cap_data.size() % FW) == FW - 1);
      end
      if (a_valid && a_ready) begin
        if (first_a < 0) first_a = cyc;
        a_sent++;
      end
      if (b_valid && b_ready) b_sent++;
      if (out_valid && out_ready) begin
        cap_data.push_back(out_data);
        cap_last.push_back(out_last);
        cap_busy.push_back(busy);
        cap_cyc.push_back(cyc);
      end
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic verifyCapture(input int frames, input bit consecutive);
    int n;
    checkOutput("word_count", cap_data.size(), frames * FW);
    n = (cap_data.size() < frames * FW) ? cap_data.size() : frames * FW;
    for (int k = 0; k < n; k++) begin
      checkOutput($sformatf("data[%0d]", k), cap_data[k], expWord(k));
      checkOutput($sformatf("last[%0d]", k), cap_last[k], (k % FW) == FW - 1);
      if (k == 0 || (k % FW) != 0) checkOutput($sformatf("busy[%0d]", k), cap_busy[k], 1);
      if (consecutive && k > 0) checkOutput($sformatf("cycle[%0d]", k), cap_cyc[k], cap_cyc[0] + k);
    end
    if (consecutive && n > 0) checkOutput("first_latency", cap_cyc[0], first_a + 1);
  endtask

  task automatic checkIdle();
    @(negedge clk);
    #1;
    checkOutput("busy_idle", busy, 0);
    checkOutput("out_valid_idle", out_valid, 0);
  endtask

  initial begin
    reset     = 1'b1;
    a_valid   = 1'b0;
    b_valid   = 1'b0;
    a_data    = '0;
    b_data    = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_last", out_last, 0);
    checkOutput("rst_out_data", out_data, 16'h0000);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_a_ready", a_ready, 1);
    checkOutput("rst_b_ready", b_ready, 0);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] single frame, b_valid held from the start");
    applyStimulus(1, 0, 0, 200);
    verifyCapture(1, 1'b1);
    checkIdle();

    $display("[TB] single frame with out_ready pattern 1,0,0,1");
    applyStimulus(1, 1, 0, 400);
    verifyCapture(1, 1'b0);
    checkIdle();

    $display("[TB] reset after 5 A words, then a full frame");
    applyStimulus(1, 0, 5, 100);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("post_reset_out_valid", out_valid, 0);
    checkOutput("post_reset_busy", busy, 0);
    reset = 1'b0;
    applyStimulus(1, 0, 0, 200);
    verifyCapture(1, 1'b1);
    checkIdle();

    $display("[TB] two back-to-back frames");
    applyStimulus(2, 0, 0, 400);
    verifyCapture(2, 1'b1);
    checkIdle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
